// File: rtl/tmip_pkg.sv
// tmip_pkg: shared constants and types for the TMIP action sequencer.
//   - action codes (ACT_*), image size codes (SZ_*)
//   - sequencer state enum
//   - default queue depth / action width
//   - sz_sanitize(): maps the unused size code 3 onto the largest size
package tmip_pkg;

  localparam int MAX_ACT_DEF = 8;
  localparam int ACT_W_DEF   = 3;

  localparam logic [2:0] ACT_GRAY_MAX = 3'd0;
  localparam logic [2:0] ACT_GRAY_AVG = 3'd1;
  localparam logic [2:0] ACT_GRAY_WGT = 3'd2;
  localparam logic [2:0] ACT_MAXPOOL  = 3'd3;
  localparam logic [2:0] ACT_NEG      = 3'd4;
  localparam logic [2:0] ACT_HFLIP    = 3'd5;
  localparam logic [2:0] ACT_MEDIAN   = 3'd6;
  localparam logic [2:0] ACT_XCORR    = 3'd7;

  localparam logic [1:0] SZ_4  = 2'd0;
  localparam logic [1:0] SZ_8  = 2'd1;
  localparam logic [1:0] SZ_16 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [1:0] sz_sanitize(input logic [1:0] code);
    return (code == 2'd3) ? SZ_16 : code;
  endfunction

endpackage

// File: rtl/tmip_act_fifo.sv
// tmip_act_fifo: DEPTH-entry circular action queue.
//   clk, rst     : clock, synchronous active-high reset
//   clr          : empty the queue; a simultaneous push lands in slot 0
//   push, din    : append one entry (ignored when full)
//   pop / pop2   : drop one / two entries from the head (pop2 wins)
//   head, nxt    : entry at the head and the one behind it
//   count        : number of valid entries; full / empty flags
module tmip_act_fifo
  import tmip_pkg::*;
#(
  parameter int DEPTH = MAX_ACT_DEF,
  parameter int W     = ACT_W_DEF,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          pop2,
  output logic [W-1:0]  head,
  output logic [W-1:0]  nxt,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head  = mem_q[rd_q];
  assign nxt   = mem_q[inc(rd_q)];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      if (push) begin
        mem_d[0] = din;
        wr_d     = inc('0);
        cnt_d    = CW'(1);
      end
    end else begin
      if (push && !full) begin
        mem_d[wr_q] = din;
        wr_d        = inc(wr_q);
        cnt_d       = cnt_d + CW'(1);
      end
      if (pop2 && cnt_q >= CW'(2)) begin
        rd_d  = inc(inc(rd_q));
        cnt_d = cnt_d - CW'(2);
      end else if (pop && !empty) begin
        rd_d  = inc(rd_q);
        cnt_d = cnt_d - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tmip_action_sched.sv
// tmip_action_sched: sequences the TMIP datapath for one action set.
//   in_valid/image_size : image-load window; size latched on its first cycle (IDLE only)
//   in_valid2/action    : action-set window, one action per cycle
//   busy                : set in progress (through the seq_done cycle)
//   cmd_*               : command to datapath, held stable until cmd_ready
//   dp_done             : datapath finished the accepted command
//   seq_done            : one-cycle completion pulse
//   err                 : sticky protocol error, cleared at the next set start
// Flips, 4x4 max-pools and adjacent negative pairs are folded in ISSUE
// (one cycle per folded entry) and never reach the datapath.
module tmip_action_sched
  import tmip_pkg::*;
#(
  parameter int MAX_ACT = MAX_ACT_DEF,
  parameter int ACT_W   = ACT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       image_size,
  input  logic             in_valid2,
  input  logic [ACT_W-1:0] action,
  output logic             busy,
  output logic             cmd_valid,
  output logic [ACT_W-1:0] cmd_op,
  output logic [1:0]       cmd_size,
  output logic             cmd_flip,
  output logic             cmd_last,
  input  logic             cmd_ready,
  input  logic             dp_done,
  output logic             seq_done,
  output logic             err
);

  localparam int CW = $clog2(MAX_ACT + 1);

  state_e           state_q, state_d;
  logic [1:0]       base_q, base_d;
  logic [1:0]       cur_q, cur_d;
  logic             flip_q, flip_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             seq_done_q, seq_done_d;
  logic             in_valid_q, in_valid_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [ACT_W-1:0] cmd_op_q, cmd_op_d;
  logic [1:0]       cmd_size_q, cmd_size_d;
  logic             cmd_flip_q, cmd_flip_d;
  logic             cmd_last_q, cmd_last_d;

  logic             f_clr, f_push, f_pop, f_pop2, f_full, f_empty;
  logic [ACT_W-1:0] f_head, f_next;
  logic [CW-1:0]    f_count;

  tmip_act_fifo #(.DEPTH(MAX_ACT), .W(ACT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (f_clr),
    .push  (f_push),
    .din   (action),
    .pop   (f_pop),
    .pop2  (f_pop2),
    .head  (f_head),
    .nxt   (f_next),
    .count (f_count),
    .full  (f_full),
    .empty (f_empty)
  );

  assign busy      = busy_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_size  = cmd_size_q;
  assign cmd_flip  = cmd_flip_q;
  assign cmd_last  = cmd_last_q;
  assign seq_done  = seq_done_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cur_d       = cur_q;
    flip_d      = flip_q;
    err_d       = err_q;
    in_valid_d  = in_valid;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_size_d  = cmd_size_q;
    cmd_flip_d  = cmd_flip_q;
    cmd_last_d  = cmd_last_q;
    f_clr       = 1'b0;
    f_push      = 1'b0;
    f_pop       = 1'b0;
    f_pop2      = 1'b0;

    // Rising edge of the load window; the image persists across sets.
    if (state_q == ST_IDLE && in_valid && !in_valid_q)
      base_d = sz_sanitize(image_size);

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid2) begin
          f_clr   = 1'b1;
          f_push  = 1'b1;
          err_d   = 1'b0;
          cur_d   = base_q;
          flip_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid2) begin
          if (f_full) err_d  = 1'b1;
          else        f_push = 1'b1;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_valid_q) begin
          // Command fields are frozen here until the datapath takes it.
          if (cmd_ready) begin
            f_pop       = 1'b1;
            cmd_valid_d = 1'b0;
            state_d     = ST_WAIT;
          end
        end else if (f_empty) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (f_head == ACT_W'(ACT_HFLIP)) begin
          flip_d = ~flip_q;
          f_pop  = 1'b1;
        end else if (f_head == ACT_W'(ACT_MAXPOOL) && cur_q == SZ_4) begin
          f_pop = 1'b1;
        end else if (f_head == ACT_W'(ACT_NEG) && f_count >= CW'(2) &&
                     f_next == ACT_W'(ACT_NEG)) begin
          f_pop2 = 1'b1;
        end else begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = f_head;
          cmd_size_d  = cur_q;
          cmd_flip_d  = flip_q;
          cmd_last_d  = (f_head == ACT_W'(ACT_XCORR));
        end
      end
      ST_WAIT: begin
        if (dp_done) begin
          if (cmd_op_q == ACT_W'(ACT_MAXPOOL) && cur_q != SZ_4)
            cur_d = cur_q - 2'd1;
          if (cmd_op_q == ACT_W'(ACT_XCORR)) begin
            f_clr   = 1'b1;          // anything queued after the final op is dropped
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (in_valid2 && state_q != ST_IDLE && state_q != ST_LOAD)
      err_d = 1'b1;
  end

  assign busy_d     = (state_d != ST_IDLE);
  assign seq_done_d = (state_d == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= SZ_4;
      cur_q       <= SZ_4;
      flip_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      in_valid_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_size_q  <= '0;
      cmd_flip_q  <= 1'b0;
      cmd_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cur_q       <= cur_d;
      flip_q      <= flip_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      seq_done_q  <= seq_done_d;
      in_valid_q  <= in_valid_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_size_q  <= cmd_size_d;
      cmd_flip_q  <= cmd_flip_d;
      cmd_last_q  <= cmd_last_d;
    end
  end

endmodule
